// File: rtl/alu_exec_unit.sv
// Multi-cycle integer execute unit: single-cycle logic/arithmetic/compare ops
// and an iterative 1-bit-per-cycle shifter, with valid/ready on both sides.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic [SHW-1:0]   r_cnt;
    logic [3:0]       r_ctrl;

    logic             w_accept;
    logic             w_is_shift;
    logic             w_start_shift;
    logic [SHW-1:0]   w_shamt;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_shifted;

    // Shift codes pass op_a through so a zero-length shift completes in one cycle.
    function automatic logic [WIDTH-1:0] alu_compute(input logic [3:0]       ctrl,
                                                     input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        sa = a;
        sb = b;
        case (ctrl)
            ALU_SUB:                   return a - b;
            ALU_AND:                   return a & b;
            ALU_OR:                    return a | b;
            ALU_XOR:                   return a ^ b;
            ALU_SLT:                   return {{(WIDTH-1){1'b0}}, (sa < sb)};
            ALU_SLTU:                  return {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL, ALU_SRL, ALU_SRA: return a;
            default:                   return a + b;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] shift_one(input logic [3:0]       ctrl,
                                                   input logic [WIDTH-1:0] v);
        case (ctrl)
            ALU_SLL: return {v[WIDTH-2:0], 1'b0};
            ALU_SRL: return {1'b0, v[WIDTH-1:1]};
            default: return {v[WIDTH-1], v[WIDTH-1:1]};
        endcase
    endfunction

    assign in_ready      = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign w_accept      = in_valid && in_ready;
    assign w_is_shift    = (alu_ctrl == ALU_SLL) || (alu_ctrl == ALU_SRL) || (alu_ctrl == ALU_SRA);
    assign w_shamt       = op_b[SHW-1:0];
    assign w_start_shift = w_is_shift && (w_shamt != '0);
    assign w_alu         = alu_compute(alu_ctrl, op_a, op_b);
    assign w_shifted     = shift_one(r_ctrl, r_work);

    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_SHIFT: begin
                if (r_cnt == CNT_ONE) w_next = S_DONE;
            end
            default: begin
                if (w_accept)
                    w_next = w_start_shift ? S_SHIFT : S_DONE;
                else if ((r_state == S_DONE) && out_ready)
                    w_next = S_IDLE;
            end
        endcase
    end

    // Accept edge: capture result or load shifter; SHIFT edges: one bit per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_work   <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_cnt    <= '0;
            r_ctrl   <= ALU_ADD;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                if (w_start_shift) begin
                    r_work <= op_a;
                    r_cnt  <= w_shamt;
                    r_ctrl <= alu_ctrl;
                end else begin
                    r_result <= w_alu;
                    r_zero   <= (w_alu == '0);
                end
            end else if (r_state == S_SHIFT) begin
                r_work <= w_shifted;
                r_cnt  <= r_cnt - CNT_ONE;
                if (r_cnt == CNT_ONE) begin
                    r_result <= w_shifted;
                    r_zero   <= (w_shifted == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results are queued at issue time
// and popped when the unit presents out_valid.
module tb_alu_exec_unit;

    localparam int W = 32;

    localparam logic [3:0] ADD  = 4'd0;
    localparam logic [3:0] SUB  = 4'd1;
    localparam logic [3:0] AND_ = 4'd2;
    localparam logic [3:0] OR_  = 4'd3;
    localparam logic [3:0] XOR_ = 4'd4;
    localparam logic [3:0] SLL  = 4'd5;
    localparam logic [3:0] SRL  = 4'd6;
    localparam logic [3:0] SRA  = 4'd7;
    localparam logic [3:0] SLT  = 4'd8;
    localparam logic [3:0] SLTU = 4'd9;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   alu_ctrl = 4'd0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_ctrl (alu_ctrl),
        .op_a     (op_a),
        .op_b     (op_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .zero     (zero)
    );

    function automatic logic [W-1:0] model(input logic [3:0] c, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        int n;
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sr;
        n  = int'(b[4:0]);
        sa = a;
        sr = sa >>> n;
        case (c)
            SUB:  return a - b;
            AND_: return a & b;
            OR_:  return a | b;
            XOR_: return a ^ b;
            SLL:  return a << n;
            SRL:  return a >> n;
            SRA:  return sr;
            SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLTU: return (a < b) ? 32'd1 : 32'd0;
            default: return a + b;
        endcase
    endfunction

    task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        exp_q.push_back(model(c, a, b));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (result !== '0) begin failures++; $display("FAIL rst_result got %h want 0", result); end
        checks++; if (zero !== 1'b0) begin failures++; $display("FAIL rst_zero got %b want 0", zero); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_cycle();
        logic [3:0]   c[7] = '{ADD, SUB, SLT, SLTU, 4'hF, AND_, XOR_};
        logic [W-1:0] a[7] = '{32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'h0F0F_0000, 32'hA5A5_A5A5};
        logic [W-1:0] b[7] = '{32'd1, 32'd5, 32'd1, 32'd1, 32'd4, 32'h00F0_F0F0, 32'hA5A5_A5A5};
        logic [W-1:0] exp;
        int lat;
        for (int i = 0; i < 7; i++) begin
            issue(c[i], a[i], b[i]);
            wait_out(lat);
            exp = exp_q.pop_front();
            checks++; if (lat !== 1) begin failures++; $display("FAIL sc%0d_latency got %0d want 1", i, lat); end
            checks++; if (result !== exp) begin failures++; $display("FAIL sc%0d_result got %h want %h", i, result, exp); end
            checks++; if (zero !== (exp == '0)) begin failures++; $display("FAIL sc%0d_zero got %b want %b", i, zero, (exp == '0)); end
            release_out();
        end
    endtask

    task automatic test_shift();
        logic [3:0]   c[4] = '{SRA, SRL, SLL, SRA};
        logic [W-1:0] a[4] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h4000_0000};
        logic [W-1:0] b[4] = '{32'h0000_0024, 32'h0000_0024, 32'h0000_001F, 32'hFFFF_FFE3};
        logic [W-1:0] exp;
        int lat;
        int n;
        int low;
        for (int i = 0; i < 4; i++) begin
            n = int'(b[i][4:0]);
            issue(c[i], a[i], b[i]);
            lat = 1;
            low = 0;
            while (!out_valid && lat < 200) begin
                if (!in_ready) low++;
                @(posedge clk);
                #1;
                lat++;
            end
            exp = exp_q.pop_front();
            checks++; if (lat !== n + 1) begin failures++; $display("FAIL sh%0d_latency got %0d want %0d", i, lat, n + 1); end
            checks++; if (low !== n) begin failures++; $display("FAIL sh%0d_busy_cycles got %0d want %0d", i, low, n); end
            checks++; if (result !== exp) begin failures++; $display("FAIL sh%0d_result got %h want %h", i, result, exp); end
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0]   c[3] = '{ADD, XOR_, OR_};
        logic [W-1:0] a[3] = '{32'h10, 32'hFF00_FF00, 32'h1};
        logic [W-1:0] b[3] = '{32'h20, 32'h0F0F_0F0F, 32'h80};
        logic [W-1:0] exp;
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_ctrl = c[0]; op_a = a[0]; op_b = b[0];
        exp_q.push_back(model(c[0], a[0], b[0]));
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            exp = exp_q.pop_front();
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL b2b%0d_valid got %b want 1", i, out_valid); end
            checks++; if (result !== exp) begin failures++; $display("FAIL b2b%0d_result got %h want %h", i, result, exp); end
            if (i < 2) begin
                alu_ctrl = c[i+1]; op_a = a[i+1]; op_b = b[i+1];
                exp_q.push_back(model(c[i+1], a[i+1], b[i+1]));
            end else begin
                in_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got %b want 0", out_valid); end
        out_ready = 1'b0;
        issue(SLL, 32'h1234_5678, 32'hFFFF_FFE0);
        wait_out(lat);
        exp = exp_q.pop_front();
        checks++; if (lat !== 1) begin failures++; $display("FAIL shift0_latency got %0d want 1", lat); end
        checks++; if (result !== exp) begin failures++; $display("FAIL shift0_result got %h want %h", result, exp); end
        release_out();
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp;
        int lat;
        issue(AND_, 32'h0000_F0F0, 32'h0000_FF00);
        wait_out(lat);
        exp = exp_q.pop_front();
        checks++; if (lat !== 1) begin failures++; $display("FAIL bp_latency got %0d want 1", lat); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = 1'($urandom_range(0, 1));
            alu_ctrl = 4'($urandom_range(0, 15));
            op_a     = $urandom;
            op_b     = $urandom;
            #1;
            checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp%0d_in_ready got %b want 0", i, in_ready); end
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1 || result !== exp) begin
                failures++; $display("FAIL bp%0d_hold got valid=%b result=%h want valid=1 result=%h", i, out_valid, result, exp);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        release_out();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
        checks++; if (result !== 32'h0000_F000) begin failures++; $display("FAIL bp_result_hold got %h want 0000f000", result); end
    endtask

    task automatic test_reset_midshift();
        logic [W-1:0] exp;
        int lat;
        issue(SRL, 32'hFFFF_0000, 32'd10);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp = exp_q.pop_front();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mrst_valid got %b want 0", out_valid); end
        checks++; if (result !== '0) begin failures++; $display("FAIL mrst_result got %h want 0", result); end
        checks++; if (zero !== 1'b0) begin failures++; $display("FAIL mrst_zero got %b want 0", zero); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mrst_in_ready got %b want 1", in_ready); end
        issue(ADD, 32'd10, 32'd20);
        wait_out(lat);
        exp = exp_q.pop_front();
        checks++; if (lat !== 1) begin failures++; $display("FAIL mrst_add_latency got %0d want 1", lat); end
        checks++; if (result !== exp) begin failures++; $display("FAIL mrst_add_result got %h want %h", result, exp); end
        release_out();
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_shift();
        test_back_to_back();
        test_backpressure();
        test_reset_midshift();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
